// File: rtl/pixelscale_pkg.sv
// Shared definitions for the 2x box-filter downscaler: FSM encoding, sum widths
// and a channel slice helper used to unpack per-channel fields from packed pixel buses.
package pixelscale_pkg;

  typedef enum logic [1:0] {StIdle, StEven, StOdd, StDone} ds_state_e;

  // Default channel width and the matching sum widths.
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PAIR_W     = DATA_W_DEF + 1;
  localparam int unsigned QUAD_W     = DATA_W_DEF + 2;

  // Widest packed bus the slice helper can unpack.
  localparam int unsigned SliceBusW = 256;

  // Sum widths for an arbitrary channel width.
  function automatic int unsigned pair_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned quad_w(input int unsigned dw);
    return dw + 2;
  endfunction

  // Field ch of width w (w <= 32) from a packed bus with channel 0 in the LSBs.
  function automatic logic [31:0] chan_slice(input logic [SliceBusW-1:0] bus,
                                             input int unsigned          ch,
                                             input int unsigned          w);
    return 32'(bus >> (ch * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/ds_line_buffer.sv
// Simple dual-port line buffer: synchronous write, combinational read, so the odd row
// can fetch the even-row pair sum in the same cycle it accepts the completing pixel.
module ds_line_buffer #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 9,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_downscale.sv
// Streaming 2x box-filter decimator: each output pixel is the per-channel mean of a
// 2x2 input block. Even rows store horizontal pair sums in a line buffer; odd rows
// complete the quad sum and load a single-entry output register.
// Build option: define PIXEL_DOWNSCALE_ROUND_EN for round-half-up, else truncation.
module pixel_downscale
  import pixelscale_pkg::*;
#(
  parameter int unsigned H_in    = 512,
  parameter int unsigned W_in    = 512,
  parameter int unsigned CHANNEL = 3,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNEL*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNEL*DATA_W-1:0] out_data,
  output logic                      complete
);

  localparam int unsigned PairW   = pair_w(DATA_W);
  localparam int unsigned QuadW   = quad_w(DATA_W);
  localparam int unsigned PixW    = CHANNEL * DATA_W;
  localparam int unsigned LbW     = CHANNEL * PairW;
  localparam int unsigned XW      = $clog2(W_in);
  localparam int unsigned YW      = $clog2(H_in);
  localparam int unsigned LbDepth = W_in / 2;
  localparam int unsigned LbAw    = (LbDepth > 1) ? $clog2(LbDepth) : 1;

`ifdef PIXEL_DOWNSCALE_ROUND_EN
  localparam int unsigned RoundAdd = 2;
`else
  localparam int unsigned RoundAdd = 0;
`endif

  ds_state_e         state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [PixW-1:0]   pair_q, pair_d;
  logic              out_valid_q, out_valid_d;
  logic [PixW-1:0]   out_data_q, out_data_d;

  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              lb_we;
  logic              load;
  logic [LbAw-1:0]   lb_addr;
  logic [LbW-1:0]    lb_wdata;
  logic [LbW-1:0]    lb_rdata;
  logic [PixW-1:0]   avg;

  assign accept   = in_valid && in_ready;
  assign last_col = (x_q == XW'(W_in - 1));
  assign last_row = (y_q == YW'(H_in - 1));
  assign lb_we    = accept && (state_q == StEven) && x_q[0];
  assign load     = accept && (state_q == StOdd) && x_q[0];
  assign lb_addr  = LbAw'(x_q >> 1);

  // Per-channel pair sum (even rows) and rounded/truncated quad average (odd rows).
  for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
    logic [DATA_W-1:0] in_px;
    logic [DATA_W-1:0] pair_px;
    logic [PairW-1:0]  lb_px;
    logic [PairW-1:0]  pair_sum;
    logic [QuadW-1:0]  quad_sum;
    logic [QuadW-1:0]  quad_avg;

    // Buses wider than SliceBusW are not supported by the slice helper.
    assign in_px    = DATA_W'(chan_slice(SliceBusW'(in_data), c, DATA_W));
    assign pair_px  = DATA_W'(chan_slice(SliceBusW'(pair_q), c, DATA_W));
    assign lb_px    = PairW'(chan_slice(SliceBusW'(lb_rdata), c, PairW));
    assign pair_sum = PairW'(in_px) + PairW'(pair_px);
    assign quad_sum = QuadW'(lb_px) + QuadW'(pair_px) + QuadW'(in_px);
    // Max quad sum plus rounding fits QuadW, and >>2 always fits DATA_W.
    assign quad_avg = (quad_sum + QuadW'(RoundAdd)) >> 2;

    assign lb_wdata[c*PairW +: PairW]   = pair_sum;
    assign avg[c*DATA_W +: DATA_W]      = DATA_W'(quad_avg);
  end

  ds_line_buffer #(
    .Depth (LbDepth),
    .Width (LbW),
    .AddrW (LbAw)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (lb_wdata),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: row parity tracks EVEN/ODD, final pixel enters DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StEven;
      StEven:         if (accept && last_col) state_d = StOdd;
      StOdd:          if (accept && last_col) state_d = last_row ? StDone : StEven;
      default:        state_d = StIdle;
    endcase
  end

  // FSM outputs: odd-row odd columns stall only when the output register cannot take data.
  always_comb begin
    in_ready = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StEven:  in_ready = 1'b1;
      StOdd:   in_ready = !x_q[0] || !out_valid_q || out_ready;
      StDone:  complete = 1'b1;
      default: ;
    endcase
  end

  // Raster counters, pair register and output register next state.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (((state_q == StIdle) || (state_q == StDone)) && start) begin
      x_d = '0;
      y_d = '0;
    end else if (accept) begin
      if (!x_q[0]) begin
        pair_d = in_data;
      end
      if (last_col) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // A reload in the drain cycle keeps out_valid high.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = avg;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
